// File: rtl/div_ctrl_pkg.sv
// Shared types and ratio legality check for the programmable clock divider.
// Optional feature: define DIV_CTRL_ODD_EN to allow odd ratios >= 3.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic div_legal(input logic [31:0] d);
        logic ok;
        ok = (d >= MIN_DIV);
`ifdef DIV_CTRL_ODD_EN
        ok = ok;
`else
        ok = ok && !d[0];
`endif
        return ok;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Ratio-configuration handshake between the register file and div_ctrl.
interface div_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             cfg_valid_i;
    logic [CNT_W-1:0] cfg_div_i;
    logic             cfg_ready_o;
    logic             cfg_err_o;

    modport master (
        output cfg_valid_i,
        output cfg_div_i,
        input  cfg_ready_o,
        input  cfg_err_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_div_i,
        output cfg_ready_o,
        output cfg_err_o
    );
endinterface

// File: rtl/div_ctrl_phase.sv
// Phase counter for the divided clock: registered clk_o/stb_o, period boundary flag.
module div_ctrl_phase #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    output logic             clk_o,
    output logic             stb_o,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic             act;

    assign cnt_nxt  = cnt + CNT_W'(1);
    assign half     = div >> 1;
    assign boundary = act && (cnt == div - CNT_W'(1));

    // A new period always starts high, independent of the ratio in effect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            clk_o <= 1'b0;
            stb_o <= 1'b0;
            act   <= 1'b0;
        end else if (load || (run && boundary)) begin
            cnt   <= '0;
            clk_o <= 1'b1;
            stb_o <= 1'b1;
            act   <= 1'b1;
        end else if (run && act) begin
            cnt   <= cnt_nxt;
            clk_o <= (cnt_nxt < half);
            stb_o <= 1'b0;
        end else begin
            cnt   <= '0;
            clk_o <= 1'b0;
            stb_o <= 1'b0;
            act   <= 1'b0;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Programmable clock divider controller: run/stop FSM, ratio handshake, boundary-aligned ratio changes.
// Odd ratios are accepted only when DIV_CTRL_ODD_EN is defined.
import div_ctrl_pkg::*;

module div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    div_ctrl_if.slave        cfg,
    output logic             clk_o,
    output logic             stb_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] div_o
);

    state_t           state;
    logic             ready_q;
    logic             err_q;
    logic             pend_q;
    logic [CNT_W-1:0] pend_div;
    logic             boundary;
    logic             xfer;
    logic             legal;
    logic             to_idle;
    logic             ph_load;
    logic             ph_run;

    assign xfer    = cfg.cfg_valid_i && ready_q;
    assign legal   = div_legal(32'(cfg.cfg_div_i));
    assign to_idle = (state != ST_IDLE) && boundary && !en_i;
    assign ph_load = (state == ST_IDLE) && en_i;
    assign ph_run  = (state != ST_IDLE) && !to_idle;

    assign cfg.cfg_ready_o = ready_q;
    assign cfg.cfg_err_o   = err_q;
    assign busy_o          = !ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            div_o    <= CNT_W'(DEFAULT_DIV);
            pend_q   <= 1'b0;
            pend_div <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            err_q <= xfer && !legal;

            case (state)
                ST_IDLE: if (en_i) state <= ST_RUN;
                ST_RUN:  if (!en_i) state <= boundary ? ST_IDLE : ST_STOP;
                ST_STOP: if (boundary) state <= en_i ? ST_RUN : ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Ready comes back one cycle after the new ratio becomes visible on div_o.
            if (pend_q && ((state == ST_IDLE) || boundary)) begin
                div_o  <= pend_div;
                pend_q <= 1'b0;
            end else if (!pend_q && !ready_q) begin
                ready_q <= 1'b1;
            end

            if (xfer && legal) begin
                ready_q <= 1'b0;
                if (state == ST_IDLE) begin
                    div_o <= cfg.cfg_div_i;
                end else begin
                    pend_q   <= 1'b1;
                    pend_div <= cfg.cfg_div_i;
                end
            end
        end
    end

    div_ctrl_phase #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (ph_load),
        .run      (ph_run),
        .div      (div_o),
        .clk_o    (clk_o),
        .stb_o    (stb_o),
        .boundary (boundary)
    );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_div_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       clk_o;
    logic       stb_o;
    logic       busy_o;
    logic [7:0] div_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    div_ctrl_if #(.CNT_W(8)) cfg_if ();

    div_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .cfg    (cfg_if.slave),
        .clk_o  (clk_o),
        .stb_o  (stb_o),
        .busy_o (busy_o),
        .div_o  (div_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag, input int d);
        chk({tag, "_clk"},   32'(clk_o), 0);
        chk({tag, "_stb"},   32'(stb_o), 0);
        chk({tag, "_div"},   32'(div_o), 32'(d));
    endtask

    initial begin
        rst_i = 1'b1;
        en_i  = 1'b0;
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_div_i   = 8'd0;

        // reset values
        @(negedge clk_i);
        @(negedge clk_i);
        chk_idle("rst", 4);
        chk("rst_ready", 32'(cfg_if.cfg_ready_o), 1);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_err",   32'(cfg_if.cfg_err_o), 0);
        rst_i = 1'b0;

        // idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk_idle("idle", 4);
            chk("idle_ready", 32'(cfg_if.cfg_ready_o), 1);
        end

        // default run D=4: 1,1,0,0 with stb at counter 0
        en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("run4_clk", 32'(clk_o), 32'((i % 4) < 2));
            chk("run4_stb", 32'(stb_o), 32'((i % 4) == 0));
        end
        @(negedge clk_i);
        chk("run4_wrap_stb", 32'(stb_o), 1);

        // change to D=8 offered while counter=1
        @(negedge clk_i);
        chk("chg_c1_clk", 32'(clk_o), 1);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_div_i   = 8'd8;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        chk("chg_busy",  32'(busy_o), 1);
        chk("chg_ready", 32'(cfg_if.cfg_ready_o), 0);
        chk("chg_div_c2", 32'(div_o), 4);
        chk("chg_clk_c2", 32'(clk_o), 0);
        @(negedge clk_i);
        chk("chg_div_c3", 32'(div_o), 4);
        chk("chg_clk_c3", 32'(clk_o), 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            chk("run8_div", 32'(div_o), 8);
            chk("run8_clk", 32'(clk_o), 32'((i % 8) < 4));
            chk("run8_stb", 32'(stb_o), 32'((i % 8) == 0));
            if (i == 0) chk("run8_ready_c0", 32'(cfg_if.cfg_ready_o), 0);
            if (i == 1) chk("run8_ready_c1", 32'(cfg_if.cfg_ready_o), 1);
        end

        // stop with D=6 pending: transfer at counter 0, drop en at counter 1
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_div_i   = 8'd6;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        chk("stop_busy", 32'(busy_o), 1);
        chk("stop_c1_clk", 32'(clk_o), 1);
        en_i = 1'b0;
        for (int k = 2; k < 8; k++) begin
            @(negedge clk_i);
            chk("stop_clk", 32'(clk_o), 32'(k < 4));
            chk("stop_stb", 32'(stb_o), 0);
            chk("stop_div", 32'(div_o), 8);
        end
        @(negedge clk_i);
        chk_idle("stop_end", 6);
        chk("stop_end_ready", 32'(cfg_if.cfg_ready_o), 0);
        @(negedge clk_i);
        chk_idle("stop_idle", 6);
        chk("stop_idle_ready", 32'(cfg_if.cfg_ready_o), 1);

        // reset while a change is pending
        en_i = 1'b1;
        @(negedge clk_i);
        chk("rr_c0_clk", 32'(clk_o), 1);
        chk("rr_c0_div", 32'(div_o), 6);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_div_i   = 8'd8;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        chk("rr_busy_pre", 32'(busy_o), 1);
        chk("rr_c1_clk",   32'(clk_o), 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        en_i  = 1'b0;
        chk_idle("rr", 4);
        chk("rr_busy",  32'(busy_o), 0);
        chk("rr_ready", 32'(cfg_if.cfg_ready_o), 1);
        @(negedge clk_i);
        chk_idle("rr_after", 4);

        // illegal D=1
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_div_i   = 8'd1;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        chk("ill1_err",   32'(cfg_if.cfg_err_o), 1);
        chk("ill1_ready", 32'(cfg_if.cfg_ready_o), 1);
        chk("ill1_div",   32'(div_o), 4);
        @(negedge clk_i);
        chk("ill1_err_end", 32'(cfg_if.cfg_err_o), 0);
        chk("ill1_div_end", 32'(div_o), 4);

        // D=7: illegal unless odd ratios are enabled
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_div_i   = 8'd7;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
`ifdef DIV_CTRL_ODD_EN
        chk("odd7_err",  32'(cfg_if.cfg_err_o), 0);
        chk("odd7_div",  32'(div_o), 7);
        chk("odd7_busy", 32'(busy_o), 1);
        @(negedge clk_i);
        chk("odd7_ready", 32'(cfg_if.cfg_ready_o), 1);
        en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("run7_clk", 32'(clk_o), 32'((i % 7) < 3));
            chk("run7_stb", 32'(stb_o), 32'((i % 7) == 0));
        end
`else
        chk("ill7_err",   32'(cfg_if.cfg_err_o), 1);
        chk("ill7_ready", 32'(cfg_if.cfg_ready_o), 1);
        chk("ill7_div",   32'(div_o), 4);
        @(negedge clk_i);
        chk("ill7_err_end", 32'(cfg_if.cfg_err_o), 0);
        chk("ill7_div_end", 32'(div_o), 4);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Run-time controller for the pixel/engine clock divider. Replaces the fixed divide-by-4 with a programmable ratio applied only at period boundaries, so downstream raster and memory logic never sees a runt pulse. Sits between the configuration register file (request/ready handshake) and every block that consumes the divided clock or its one-cycle strobe.

## Interface
- `CNT_W`, 8: width of the divide ratio and phase counter.
- `DEFAULT_DIV`, 4: ratio loaded at reset. Must be legal under the active configuration.

- `clk_i` in 1: system clock. All logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: run request. Level-sensitive.
- `cfg_valid_i` in 1: new ratio offered.
- `cfg_div_i` in CNT_W: offered ratio.
- `cfg_ready_o` out 1: controller can accept a ratio.
- `cfg_err_o` out 1: one-cycle pulse when an illegal ratio is offered.
- `clk_o` out 1: divided clock, registered.
- `stb_o` out 1: one-cycle pulse in the same cycle `clk_o` rises.
- `busy_o` out 1: an accepted ratio is waiting to take effect.
- `div_o` out CNT_W: ratio currently in effect.

## Operation
- **Reset values:** `clk_o`=0, `stb_o`=0, `cfg_err_o`=0, `busy_o`=0, `cfg_ready_o`=1, `div_o`=`DEFAULT_DIV`, counter=0, state IDLE.
- **Period of ratio D:**
  - Counter runs 0..D-1, then wraps to 0.
  - High phase is counter < (D>>1). Low phase is the remaining D-(D>>1) cycles.
  - The period boundary is the cycle where counter == D-1.
- **States:**
  - **IDLE:** `clk_o`=0, counter held at 0. `en_i`=1 moves to RUN.
  - **RUN:** counter advances every cycle. `en_i`=0 moves to STOP.
  - **STOP:** the current period completes. At the boundary go to IDLE, unless `en_i` has reasserted, in which case continue RUN with no gap.
- **Handshake:**
  - A transfer occurs when `cfg_valid_i` and `cfg_ready_o` are both high.
  - A legal ratio is latched as pending. `busy_o`=1 and `cfg_ready_o`=0 until it is applied.
  - In IDLE, the pending ratio is applied in the next cycle.
  - In RUN or STOP, it is applied at the boundary. The following counter=0 uses the new D.
- **Legality:**
  - D < 2 is illegal.
  - Odd D is illegal unless the odd-ratio feature is enabled (see Configuration).
  - An illegal D is consumed: `cfg_ready_o` stays 1, `cfg_err_o` pulses for one cycle, and state is unchanged.
- **Simultaneous events:**
  - A stop and a pending change at the same boundary are both applied. The controller enters IDLE with the new `div_o`.
  - A transfer and a boundary in the same cycle: the new ratio waits for the next boundary.
- **Reset mid-period:** reset overrides everything. The pending ratio is discarded and `clk_o` drops in the next cycle.

## Timing
- `en_i` sampled high in IDLE at cycle N gives `clk_o`=1 and `stb_o`=1 at cycle N+1.
- `stb_o` repeats every D cycles.
- `div_o` updates in the same cycle the new period's first `clk_o` rising edge is driven (counter=0).
- For a change accepted in IDLE, `div_o` updates one cycle after the transfer.
- `cfg_ready_o` returns to 1 in the cycle after the ratio is applied.
- The first change can be accepted 1 cycle after reset deasserts. At most one change is pending at a time.
- Worst-case change latency is D_old+1 cycles from transfer.

## Configuration
- **`DIV_CTRL_ODD_EN` defined:** odd D ≥ 3 is legal. The high phase is the shorter one, e.g. D=5 gives 2 cycles high and 3 low.
- **`DIV_CTRL_ODD_EN` undefined:** odd D raises `cfg_err_o`. Only even duty-50% ratios are produced.

## Structure
- **Shared package/header `div_ctrl_pkg`:**
  - State encoding: IDLE, RUN, STOP.
  - `MIN_DIV`=2.
  - The legality check, as a function/macro.
- **Sub-module `div_ctrl_phase`:** the counter and `clk_o`/`stb_o` generation.
  - Inputs: `load`, `div`, `run`.
  - Outputs: `boundary`.
  - The parent owns the FSM, the handshake and the pending register.

## Test plan
- **Reset and idle:** reset, hold `en_i`=0 for 20 cycles → `clk_o`=0, `stb_o`=0, `div_o`=4, `cfg_ready_o`=1 throughout.
- **Default run:** `en_i`=1 with D=4 → `clk_o` pattern 1,1,0,0 repeating. `stb_o` every 4 cycles, starting 1 cycle after `en_i`.
- **Change mid-period:** RUN at D=4, transfer D=8 at counter=1 → `busy_o`=1 and `cfg_ready_o`=0. At the boundary 2 cycles later, `div_o`=8, then 4 high and 4 low cycles.
- **Illegal ratios:**
  - Offer D=1 → `cfg_err_o` pulses once and `div_o` is unchanged.
  - Offer D=7 → error without `DIV_CTRL_ODD_EN`; with it, 3 high and 4 low cycles.
- **Stop with pending change:** drop `en_i` mid-high-phase while D=6 is pending → the period completes, then IDLE with `div_o`=6 and `clk_o`=0, with no pulse shorter than its phase.
- **Reset mid-operation:** assert `rst_i` while pending → `clk_o`=0 the next cycle, `div_o`=4, `busy_o`=0.
